// File: rtl/fattree_up_port_sched_pkg.sv
// ---------------------------------------------------------------------------
// fattree_up_port_sched_pkg
// Shared definitions for the fat-tree up-port scheduler:
//   K_DEF / NI_DEF   default radix and number of requesting inputs
//   Kw / NIw / CNTw  derived widths (port index, input index, load counter)
//   sched_st_t       per-input binding state
//   width_of()       index width of an n-entry set, at least 1 bit
//   onehot2bin()     index of the set bit of a one-hot vector
// ---------------------------------------------------------------------------
package fattree_up_port_sched_pkg;

   localparam int K_DEF  = 2;
   localparam int NI_DEF = 2;

   // Width needed to index n items; a 1-entry set still gets one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int Kw   = width_of(K_DEF);
   localparam int NIw  = width_of(NI_DEF);
   localparam int CNTw = width_of(NI_DEF + 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } sched_st_t;

   // OR of the indices of all set bits; exact for a one-hot input, 0 for all-zero.
   function automatic logic [31:0] onehot2bin(input logic [31:0] oh);
      logic [31:0] b;
      b = 32'd0;
      for (int n = 0; n < 32; n++) begin
         if (oh[n]) begin
            b = b | 32'(n);
         end else begin
            b = b | 32'd0;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/fattree_min_load_pick.sv
// ---------------------------------------------------------------------------
// fattree_min_load_pick
// Combinational least-loaded port picker with round-robin tie-break.
// Scans the candidates starting at ptr and keeps the first one seen with the
// strictly smallest load, so equal loads resolve to the earliest port at or
// after ptr.
// Ports:
//   cand   in  K        usable ports
//   load   in  K*CNTW   per-port load, port j at bits j*CNTW +: CNTW
//   ptr    in  KW       round-robin start position
//   win    out K        one-hot winner (0 when no candidate)
//   valid  out 1        a winner exists
// ---------------------------------------------------------------------------
module fattree_min_load_pick
   import fattree_up_port_sched_pkg::*;
#(
   parameter int K    = K_DEF,
   parameter int KW   = Kw,
   parameter int CNTW = CNTw
) (
   input  logic [K-1:0]      cand,
   input  logic [K*CNTW-1:0] load,
   input  logic [KW-1:0]     ptr,
   output logic [K-1:0]      win,
   output logic              valid
);

   localparam logic [K-1:0] ONE_K = {{(K-1){1'b0}}, 1'b1};

   logic [CNTW-1:0] load_a [K];
   logic [CNTW-1:0] best_s;
   logic [KW-1:0]   idx_s;

   for (genvar j = 0; j < K; j++) begin : g_unpack
      assign load_a[j] = load[j*CNTW +: CNTW];
   end

   // Round-robin ordered scan; strict less-than keeps the earliest tie.
   always_comb begin
      win    = '0;
      valid  = 1'b0;
      best_s = '0;
      idx_s  = '0;
      for (int off = 0; off < K; off++) begin
         idx_s = KW'((int'(ptr) + off) % K);
         if (cand[idx_s] && (!valid || (load_a[idx_s] < best_s))) begin
            valid  = 1'b1;
            best_s = load_a[idx_s];
            win    = ONE_K << idx_s;
         end else begin
            // earlier or lighter candidate stands
         end
      end
   end

endmodule

// File: rtl/fattree_up_port_sched.sv
// ---------------------------------------------------------------------------
// fattree_up_port_sched
// Packet-level up-port scheduler. Binds one new head-of-packet request per
// cycle to the least-loaded usable up port and holds that binding until the
// packet's tail is forwarded, keeping each packet on one up path.
// Ports:
//   clk        in  1        clock
//   reset      in  1        asynchronous active-low reset
//   req        in  NI       head flit waiting for an up port
//   tail_done  in  NI       tail of input i's bound packet forwarded
//   up_avail   in  K        up port has a free VC with credit
//   up_mask    in  K        0 = port unusable for new bindings
//   gnt        out NI       one-hot single-cycle grant pulse
//   gnt_port   out KW       port bound with gnt, 0 otherwise
//   sel        out NI*K     held one-hot binding per input (slice i*K +: K)
//   locked     out NI       input holds a binding
//   up_load    out K*CNTW   packets in flight per port (j*CNTW +: CNTW)
//   err_tail   out 1        tail_done seen on an unbound input
// ---------------------------------------------------------------------------
module fattree_up_port_sched
   import fattree_up_port_sched_pkg::*;
#(
   parameter  int K    = K_DEF,
   parameter  int NI   = NI_DEF,
   localparam int KW   = width_of(K),
   localparam int NIW  = width_of(NI),
   localparam int CNTW = width_of(NI + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NI-1:0]     req,
   input  logic [NI-1:0]     tail_done,
   input  logic [K-1:0]      up_avail,
   input  logic [K-1:0]      up_mask,
   output logic [NI-1:0]     gnt,
   output logic [KW-1:0]     gnt_port,
   output logic [NI*K-1:0]   sel,
   output logic [NI-1:0]     locked,
   output logic [K*CNTW-1:0] up_load,
   output logic              err_tail
);

   localparam int              CNT_MAX   = (1 << CNTW) - 1;
   localparam logic [CNTW-1:0] CNT_MAX_V = '1;
   localparam logic [NI-1:0]   ONE_NI    = {{(NI-1){1'b0}}, 1'b1};

   sched_st_t         st_r [NI];
   logic [NI*K-1:0]   sel_r;
   logic [NI-1:0]     gnt_r;
   logic [KW-1:0]     gnt_port_r;
   logic [CNTW-1:0]   load_r [K];
   logic [CNTW-1:0]   load_nxt_s [K];
   logic [K*CNTW-1:0] load_flat_s;
   logic [NIW-1:0]    ptr_in_r;
   logic [KW-1:0]     ptr_up_r;
   logic              err_r;

   logic [NI-1:0]     locked_s;
   logic [NI-1:0]     elig_s;
   logic [NI-1:0]     release_s;
   logic              in_valid_s;
   logic [NIW-1:0]    in_idx_s;
   logic [NIW-1:0]    scan_in_s;
   logic [K-1:0]      cand_s;
   logic [K-1:0]      win_s;
   logic              up_valid_s;
   logic              grant_s;
   logic [KW-1:0]     port_s;
   int                cnt_s;

   for (genvar j = 0; j < K; j++) begin : g_flat
      assign load_flat_s[j*CNTW +: CNTW] = load_r[j];
   end

   // Decode per-input FSM state into the locked vector.
   always_comb begin
      locked_s = '0;
      for (int i = 0; i < NI; i++) begin
         locked_s[i] = (st_r[i] == ST_LOCKED);
      end
   end

   // A tail only releases a bound input; an input releasing this edge is still
   // locked here and so cannot be re-granted in the same decision.
   assign elig_s    = req & ~locked_s;
   assign release_s = tail_done & locked_s;
   assign cand_s    = up_avail & up_mask;

   // Input round-robin: first eligible input at or after ptr_in.
   always_comb begin
      in_valid_s = 1'b0;
      in_idx_s   = '0;
      scan_in_s  = '0;
      for (int off = 0; off < NI; off++) begin
         scan_in_s = NIW'((int'(ptr_in_r) + off) % NI);
         if (!in_valid_s && elig_s[scan_in_s]) begin
            in_valid_s = 1'b1;
            in_idx_s   = scan_in_s;
         end else begin
            // earlier winner stands
         end
      end
   end

   fattree_min_load_pick #(
      .K    (K),
      .KW   (KW),
      .CNTW (CNTW)
   ) u_pick (
      .cand  (cand_s),
      .load  (load_flat_s),
      .ptr   (ptr_up_r),
      .win   (win_s),
      .valid (up_valid_s)
   );

   assign grant_s = in_valid_s & up_valid_s;
   assign port_s  = KW'(onehot2bin(32'(win_s)));

   // Next per-port load: +1 for a new binding, -1 per released binding; a
   // grant and a release on the same port cancel. Result is clamped.
   always_comb begin
      cnt_s = 0;
      for (int j = 0; j < K; j++) begin
         cnt_s = int'(load_r[j]);
         if (grant_s && win_s[j]) begin
            cnt_s = cnt_s + 1;
         end else begin
            cnt_s = cnt_s + 0;
         end
         for (int i = 0; i < NI; i++) begin
            if (release_s[i] && sel_r[i*K + j]) begin
               cnt_s = cnt_s - 1;
            end else begin
               cnt_s = cnt_s - 0;
            end
         end
         if (cnt_s < 0) begin
            load_nxt_s[j] = '0;
         end else if (cnt_s > CNT_MAX) begin
            load_nxt_s[j] = CNT_MAX_V;
         end else begin
            load_nxt_s[j] = CNTW'(cnt_s);
         end
      end
   end

   // Binding FSMs, pointers, load counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NI; i++) begin
            st_r[i] <= ST_IDLE;
         end
         for (int j = 0; j < K; j++) begin
            load_r[j] <= '0;
         end
         sel_r      <= '0;
         gnt_r      <= '0;
         gnt_port_r <= '0;
         ptr_in_r   <= '0;
         ptr_up_r   <= '0;
         err_r      <= 1'b0;
      end else begin
         gnt_r      <= '0;
         gnt_port_r <= '0;
         err_r      <= |(tail_done & ~locked_s);
         for (int i = 0; i < NI; i++) begin
            if (release_s[i]) begin
               st_r[i]          <= ST_IDLE;
               sel_r[i*K +: K]  <= '0;
            end else if (grant_s && (in_idx_s == NIW'(i))) begin
               st_r[i]          <= ST_LOCKED;
               sel_r[i*K +: K]  <= win_s;
            end
         end
         for (int j = 0; j < K; j++) begin
            load_r[j] <= load_nxt_s[j];
         end
         if (grant_s) begin
            gnt_r      <= ONE_NI << in_idx_s;
            gnt_port_r <= port_s;
            ptr_in_r   <= (in_idx_s == NIW'(NI - 1)) ? '0 : in_idx_s + 1'b1;
            ptr_up_r   <= (port_s == KW'(K - 1)) ? '0 : port_s + 1'b1;
         end
      end
   end

   assign gnt      = gnt_r;
   assign gnt_port = gnt_port_r;
   assign sel      = sel_r;
   assign locked   = locked_s;
   assign up_load  = load_flat_s;
   assign err_tail = err_r;

endmodule

// File: tb/tb_fattree_up_port_sched.sv
// ---------------------------------------------------------------------------
// tb_fattree_up_port_sched
// Self-checking bench for fattree_up_port_sched (K=2, NI=2). A reference
// model tracks which port each input is bound to; loads are recomputed as the
// number of inputs bound to each port. Directed steps follow the scheduler's
// scenarios, then a randomized phase with legal requester behaviour.
// ---------------------------------------------------------------------------
module tb_fattree_up_port_sched;

   logic       clk;
   logic       reset;
   logic [1:0] req;
   logic [1:0] tail_done;
   logic [1:0] up_avail;
   logic [1:0] up_mask;
   logic [1:0] gnt;
   logic [0:0] gnt_port;
   logic [3:0] sel;
   logic [1:0] locked;
   logic [3:0] up_load;
   logic       err_tail;

   int checks;
   int errors;

   // reference model state
   int         bnd [2];
   int         m_ptr_in;
   int         m_ptr_up;
   logic [1:0] e_gnt;
   logic [0:0] e_port;
   logic [3:0] e_sel;
   logic [1:0] e_locked;
   logic [3:0] e_load;
   logic       e_err;

   logic [1:0] pend;
   logic [1:0] rtd;
   logic [1:0] rav;
   logic [1:0] rmk;

   fattree_up_port_sched dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .tail_done (tail_done),
      .up_avail  (up_avail),
      .up_mask   (up_mask),
      .gnt       (gnt),
      .gnt_port  (gnt_port),
      .sel       (sel),
      .locked    (locked),
      .up_load   (up_load),
      .err_tail  (err_tail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      bnd[0] = -1;
      bnd[1] = -1;
      m_ptr_in = 0;
      m_ptr_up = 0;
   endtask

   // One clock of the scheduler rules, evaluated on the sampled inputs.
   task automatic model_step(input logic [1:0] r, input logic [1:0] td,
                             input logic [1:0] av, input logic [1:0] mk);
      int ld [2];
      int gi;
      int gp;
      int x;
      e_err = 1'b0;
      ld[0] = 0;
      ld[1] = 0;
      for (int i = 0; i < 2; i++) begin
         if (td[i] && bnd[i] < 0) e_err = 1'b1;
         if (bnd[i] >= 0) ld[bnd[i]] = ld[bnd[i]] + 1;
      end
      gi = -1;
      for (int off = 0; off < 2; off++) begin
         x = (m_ptr_in + off) % 2;
         if (gi < 0 && r[x] && bnd[x] < 0) gi = x;
      end
      gp = -1;
      for (int off = 0; off < 2; off++) begin
         x = (m_ptr_up + off) % 2;
         if (av[x] && mk[x] && (gp < 0 || ld[x] < ld[gp])) gp = x;
      end
      for (int i = 0; i < 2; i++) begin
         if (td[i] && bnd[i] >= 0) bnd[i] = -1;
      end
      e_gnt  = 2'b00;
      e_port = 1'b0;
      if (gi >= 0 && gp >= 0) begin
         bnd[gi]   = gp;
         e_gnt[gi] = 1'b1;
         e_port    = 1'(gp);
         m_ptr_in  = (gi + 1) % 2;
         m_ptr_up  = (gp + 1) % 2;
      end
      e_sel    = 4'b0000;
      e_locked = 2'b00;
      ld[0] = 0;
      ld[1] = 0;
      for (int i = 0; i < 2; i++) begin
         if (bnd[i] >= 0) begin
            e_locked[i]          = 1'b1;
            e_sel[i*2 + bnd[i]]  = 1'b1;
            ld[bnd[i]]           = ld[bnd[i]] + 1;
         end
      end
      e_load = {2'(ld[1]), 2'(ld[0])};
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".gnt"},      32'(gnt),      32'(e_gnt));
      check({tag, ".gnt_port"}, 32'(gnt_port), 32'(e_port));
      check({tag, ".sel"},      32'(sel),      32'(e_sel));
      check({tag, ".locked"},   32'(locked),   32'(e_locked));
      check({tag, ".up_load"},  32'(up_load),  32'(e_load));
      check({tag, ".err_tail"}, 32'(err_tail), 32'(e_err));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".gnt"},      32'(gnt),      32'd0);
      check({tag, ".gnt_port"}, 32'(gnt_port), 32'd0);
      check({tag, ".sel"},      32'(sel),      32'd0);
      check({tag, ".locked"},   32'(locked),   32'd0);
      check({tag, ".up_load"},  32'(up_load),  32'd0);
      check({tag, ".err_tail"}, 32'(err_tail), 32'd0);
   endtask

   // Drive inputs, take one clock edge, advance the model, compare #1 later.
   task automatic step(input string tag, input logic [1:0] r, input logic [1:0] td,
                       input logic [1:0] av, input logic [1:0] mk);
      req       = r;
      tail_done = td;
      up_avail  = av;
      up_mask   = mk;
      @(posedge clk);
      model_step(r, td, av, mk);
      #1;
      compare_all(tag);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      req       = 2'b00;
      tail_done = 2'b00;
      up_avail  = 2'b00;
      up_mask   = 2'b00;
      pend      = 2'b00;
      model_reset();
      #12;
      check_zero("reset");
      reset = 1'b1;

      // basic grant, then load balancing onto the idle port
      step("basic", 2'b01, 2'b00, 2'b11, 2'b11);
      check("basic_gnt", 32'(gnt), 32'h1);
      check("basic_load", 32'(up_load), 32'h1);
      step("balance", 2'b10, 2'b00, 2'b11, 2'b11);
      check("balance_port", 32'(gnt_port), 32'h1);
      check("balance_load", 32'(up_load), 32'h5);
      step("drain", 2'b00, 2'b11, 2'b11, 2'b11);

      // fairness with single-flit packets
      step("fair0", 2'b11, 2'b00, 2'b11, 2'b11);
      check("fair0_gnt", 32'(gnt), 32'h1);
      step("fair1", 2'b11, 2'b01, 2'b11, 2'b11);
      check("fair1_gnt", 32'(gnt), 32'h2);
      check("fair1_port", 32'(gnt_port), 32'h1);
      step("fair2", 2'b11, 2'b10, 2'b11, 2'b11);
      check("fair2_gnt", 32'(gnt), 32'h1);
      check("fair2_port", 32'(gnt_port), 32'h0);
      step("fair3", 2'b11, 2'b01, 2'b11, 2'b11);
      check("fair3_gnt", 32'(gnt), 32'h2);
      step("fair_end", 2'b00, 2'b10, 2'b11, 2'b11);

      // availability restricted to port0; same-cycle grant and release on port0
      step("avail0", 2'b11, 2'b00, 2'b01, 2'b11);
      step("simul", 2'b11, 2'b01, 2'b01, 2'b11);
      check("simul_port", 32'(gnt_port), 32'h0);
      check("simul_load", 32'(up_load), 32'h1);
      step("mask_rel", 2'b00, 2'b10, 2'b11, 2'b01);
      step("mask0", 2'b01, 2'b00, 2'b11, 2'b01);
      check("mask0_port", 32'(gnt_port), 32'h0);
      step("empty", 2'b11, 2'b00, 2'b00, 2'b11);
      check("empty_gnt", 32'(gnt), 32'h0);
      step("after_empty", 2'b10, 2'b00, 2'b11, 2'b11);

      // stray tail on an idle input
      step("rel0", 2'b00, 2'b01, 2'b11, 2'b11);
      step("stray", 2'b00, 2'b01, 2'b11, 2'b11);
      check("stray_err", 32'(err_tail), 32'h1);
      step("stray_end", 2'b00, 2'b00, 2'b11, 2'b11);
      check("stray_clear", 32'(err_tail), 32'h0);

      // reset with both inputs bound
      step("relock", 2'b01, 2'b00, 2'b11, 2'b11);
      check("relock_locked", 32'(locked), 32'h3);
      reset = 1'b0;
      #1;
      check_zero("midreset");
      #2;
      reset = 1'b1;
      model_reset();
      step("post_reset", 2'b11, 2'b00, 2'b11, 2'b11);
      check("post_reset_gnt", 32'(gnt), 32'h1);
      check("post_reset_port", 32'(gnt_port), 32'h0);
      step("post_drain", 2'b00, 2'b01, 2'b11, 2'b11);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (bnd[i] < 0 && !pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
            if (bnd[i] >= 0) rtd[i] = ($urandom_range(0, 2) == 0);
            else             rtd[i] = ($urandom_range(0, 19) == 0);
         end
         rav = 2'($urandom_range(0, 3));
         rmk = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         step("rand", pend, rtd, rav, rmk);
         for (int i = 0; i < 2; i++) begin
            if (e_gnt[i]) pend[i] = 1'b0;
         end
      end

      step("final", 2'b00, e_locked, 2'b11, 2'b11);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fattree_up_port_sched.md
# fattree_up_port_sched

Packet-level up-port scheduler for a fat-tree leaf or intermediate router. It receives up-link requests from the router's NI down-side inputs and binds each new packet to one of the K up ports. The choice is the least-loaded usable port, with round-robin tie-break. A binding is held until the packet's tail is forwarded, which keeps every packet on a single up path. The block sits beside the router's routing/VC-allocation stage and replaces static up-port selection.

## Interface
- K, default 2: fat-tree radix; number of up ports.
- NI, default 2: number of requesting inputs, normally K.
- Derived (package): Kw = log2(K), NIw = log2(NI), CNTw = log2(NI+1).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NI  input i has a head flit waiting for an up port; held high until granted.
- tail_done  in  NI  tail flit of input i's bound packet was forwarded this cycle.
- up_avail  in  K  up port j has at least one free VC with credit.
- up_mask  in  K  static config; 0 = port j unusable (failed or pruned link).
- gnt  out  NI  one-hot grant pulse, at most one bit per cycle.
- gnt_port  out  Kw  up port bound at this gnt; 0 when gnt==0.
- sel  out  NI*K  held one-hot binding per input (slice i = bits i*K+:K).
- locked  out  NI  input i currently holds a binding.
- up_load  out  K*CNTw  packets in flight per up port.
- err_tail  out  1  one-cycle pulse: tail_done seen on an unlocked input.

## Operation
- Per-input FSM with two states:
  - IDLE → LOCKED on gnt[i].
  - LOCKED → IDLE on tail_done[i].
- Only one new binding is made per cycle.
- Eligible inputs = req & ~locked. The input rr pointer picks the first eligible input at or after ptr_in.
- Candidate ports = up_avail & up_mask.
  - Pick the candidate with minimum up_load.
  - On equal load, pick the first candidate at or after ptr_up.
- If either set is empty, there is no grant and no pointer moves.
- On a grant:
  - ptr_in ← granted input + 1 (mod NI).
  - ptr_up ← chosen port + 1 (mod K).
  - up_load[port] increments.
  - sel[i] ← one-hot(port).
- On tail_done[i] while LOCKED:
  - up_load of the bound port decrements.
  - sel[i] ← 0.
- Increment and decrement on the same port in the same cycle: net zero.
- Counters are saturating. Increment at max and decrement at 0 are blocked; neither occurs in legal use.
- tail_done on an IDLE input: ignored, err_tail pulses.
- up_mask changes do not disturb existing bindings; they affect new decisions only.

## Timing
- Reset values (asynchronous assert): every output 0, all FSMs IDLE, both pointers 0, all loads 0.
- Decisions are taken from inputs sampled at edge t. gnt, gnt_port, sel, locked and up_load show the result in cycle t+1; grant latency is 1 cycle.
- gnt is a single-cycle pulse.
- The requester drops req in the cycle it sees gnt. A req still high that cycle is ignored because locked=1.
- Earliest tail_done is the cycle gnt is visible (single-flit packet). locked clears at the following edge.
- An input releasing at edge t is not eligible for a new grant decided at edge t; it can be re-granted at edge t+1 at the earliest.
- Reset asserted mid-packet drops all bindings immediately. The surrounding router is reset together with this block.

## Structure
- Package entries:
  - Kw, NIw, CNTw.
  - Enum sched_st_t {ST_IDLE, ST_LOCKED}.
  - Function onehot2bin.
- Sub-module fattree_min_load_pick: combinational. Inputs are the candidate mask, the K load values and ptr_up. Output is a one-hot winner plus a valid flag. It is reusable by the root-level scheduler.
- Top level holds: per-input FSMs, the input round-robin arbiter, the pointers, the load counters and the error flag.

## Test plan
- Basic grant: K=2, NI=2. After reset, req=01, up_avail=11, mask=11 → cycle+1 gnt=01, gnt_port=0, locked=01, up_load={0,1}.
- Load balancing: input0 on port0 is still locked; raise req=10 → gnt=10, gnt_port=1 (load 1 vs 0), up_load={1,1}.
- Fairness: req=11 held, single-flit packets (tail_done the cycle after each gnt), all loads equal → grants alternate inputs 0,1,0,1 and ports 0,1,0,1.
- Availability and mask: up_avail=01 or mask=01 → every grant on port0. Candidates empty (up_avail=00) with req=11 → gnt stays 0 and pointers are unchanged.
- Simultaneous events: input0 tail_done on port0 in the same cycle input1 is granted port0 → up_load[0] unchanged. Stray tail_done on an IDLE input → err_tail=1 for 1 cycle.
- Reset mid-operation: reset low with two inputs locked → sel, locked, up_load and gnt are 0 asynchronously. After release, the first grant uses port0 and input0.
